// File: rtl/jk_drv_seq.sv
// JK flip-flop drive sequencer: queues {op,len} commands, drives j/k for len cycles each,
// and tracks the expected downstream flip-flop state to flag a sticky mismatch.

module jk_drv_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from registered occupancy only, so the ready path stays short.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// state | meaning
// IDLE  | j=k=0, waiting for a queued command
// RUN   | driving the loaded op on j/k, remaining cycles counting down
module jk_drv_seq #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             busy,
    output logic             mismatch,
    output logic [7:0]       done_cnt
);

    localparam int EW = 2 + LEN_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       jk_q, jk_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             exp_q_q, exp_q_d;
    logic             exp_valid_q, exp_valid_d;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       done_cnt_q, done_cnt_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [EW-1:0]    head;
    logic [1:0]       head_op;
    logic [LEN_W-1:0] head_len;
    logic [LEN_W-1:0] head_len_eff;
    logic             cmd_done;

    jk_drv_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .pop_i   (fifo_pop),
        .wdata_i ({cmd_op, cmd_len}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready    = !fifo_full;
    assign head_op      = head[EW-1:LEN_W];
    assign head_len     = head[LEN_W-1:0];
    assign head_len_eff = (head_len == '0) ? LEN_W'(1) : head_len;

    always_comb begin
        state_d  = state_q;
        jk_d     = jk_q;
        rem_d    = rem_q;
        fifo_pop = 1'b0;
        cmd_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                jk_d = 2'b00;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    jk_d     = head_op;
                    rem_d    = head_len_eff;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (rem_q == LEN_W'(1)) begin
                    cmd_done = 1'b1;
                    // Chain straight into the next command so j/k never bubble through 00.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        jk_d     = head_op;
                        rem_d    = head_len_eff;
                    end else begin
                        jk_d    = 2'b00;
                        rem_d   = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end
            default: begin
                jk_d    = 2'b00;
                rem_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Reference JK model driven by the j/k values currently on the outputs.
    always_comb begin
        exp_q_d     = exp_q_q;
        exp_valid_d = exp_valid_q;
        mismatch_d  = mismatch_q;
        done_cnt_d  = done_cnt_q;
        case (jk_q)
            2'b01:   exp_q_d = 1'b0;
            2'b10:   exp_q_d = 1'b1;
            2'b11:   exp_q_d = !exp_q_q;
            default: exp_q_d = exp_q_q;
        endcase
        if (jk_q == 2'b01 || jk_q == 2'b10) begin
            exp_valid_d = 1'b1;
        end
        if (exp_valid_q && (q_fb != exp_q_q)) begin
            mismatch_d = 1'b1;
        end
        if (cmd_done) begin
            done_cnt_d = done_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            jk_q        <= 2'b00;
            rem_q       <= '0;
            exp_q_q     <= 1'b0;
            exp_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            done_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            jk_q        <= jk_d;
            rem_q       <= rem_d;
            exp_q_q     <= exp_q_d;
            exp_valid_q <= exp_valid_d;
            mismatch_q  <= mismatch_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign j         = jk_q[1];
    assign k         = jk_q[0];
    assign exp_q     = exp_q_q;
    assign exp_valid = exp_valid_q;
    assign busy      = (state_q == S_RUN);
    assign mismatch  = mismatch_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_jk_drv_seq.sv
// Directed bench for jk_drv_seq with a behavioural JK flip-flop on the feedback path.

module tb_jk_drv_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_len;
    logic       j;
    logic       k;
    logic       q_fb;
    logic       exp_q;
    logic       exp_valid;
    logic       busy;
    logic       mismatch;
    logic [7:0] done_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // 0: real flip-flop, 1: stuck at 0, 2: random garbage
    int   q_mode = 0;
    logic ff_q   = 1'b1;
    logic garb   = 1'b0;

    always #5 clk = ~clk;

    jk_drv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .exp_q     (exp_q),
        .exp_valid (exp_valid),
        .busy      (busy),
        .mismatch  (mismatch),
        .done_cnt  (done_cnt)
    );

    always @(posedge clk) begin
        case ({j, k})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
        endcase
    end

    always @(negedge clk) garb = 1'($urandom_range(0, 1));

    assign q_fb = (q_mode == 0) ? ff_q : (q_mode == 1) ? 1'b0 : garb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push1(input logic [1:0] op, input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [1:0] t2_op  [3] = '{2'b10, 2'b11, 2'b01};
    logic [3:0] t2_len [3] = '{4'd1, 4'd2, 4'd1};
    logic [1:0] t2_jk  [6] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    logic       t2_eq  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    logic [1:0] t3_op  [5] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [3:0] t3_len [5] = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd2};
    logic       t3_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] t3_jk  [8] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 4'd0;

        // Reset values, then a single Set of length 3
        do_reset();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_jk", 32'({j, k}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_expq", 32'(exp_q), 32'd0);
        chk("rst_expv", 32'(exp_valid), 32'd0);
        chk("rst_mism", 32'(mismatch), 32'd0);
        chk("rst_done", 32'(done_cnt), 32'd0);
        push1(2'b10, 4'd3);
        chk("set3_jk_e0", 32'({j, k}), 32'd0);
        tick();
        chk("set3_jk_e1", 32'({j, k}), 32'b10);
        chk("set3_busy", 32'(busy), 32'd1);
        chk("set3_expv_e1", 32'(exp_valid), 32'd0);
        tick();
        chk("set3_jk_e2", 32'({j, k}), 32'b10);
        chk("set3_expq_e2", 32'(exp_q), 32'd1);
        chk("set3_expv_e2", 32'(exp_valid), 32'd1);
        tick();
        chk("set3_jk_e3", 32'({j, k}), 32'b10);
        tick();
        chk("set3_jk_e4", 32'({j, k}), 32'd0);
        chk("set3_done", 32'(done_cnt), 32'd1);
        chk("set3_idle", 32'(busy), 32'd0);
        tick();
        chk("set3_mism", 32'(mismatch), 32'd0);

        // Back-to-back commands chain without a bubble
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                cmd_valid = 1'b1;
                cmd_op    = t2_op[c];
                cmd_len   = t2_len[c];
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            chk($sformatf("b2b_jk_%0d", c), 32'({j, k}), 32'(t2_jk[c]));
            chk($sformatf("b2b_expq_%0d", c), 32'(exp_q), 32'(t2_eq[c]));
        end
        cmd_valid = 1'b0;
        chk("b2b_done", 32'(done_cnt), 32'd3);
        tick();
        chk("b2b_mism", 32'(mismatch), 32'd0);

        // Fill the FIFO while busy; the fifth push must be refused
        do_reset();
        push1(2'b10, 4'd8);
        tick();
        chk("full_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 5; c++) begin
            cmd_valid = 1'b1;
            cmd_op    = t3_op[c];
            cmd_len   = t3_len[c];
            chk($sformatf("full_rdy_%0d", c), 32'(cmd_ready), 32'(t3_rdy[c]));
            tick();
        end
        cmd_valid = 1'b0;
        chk("full_rdy_hold", 32'(cmd_ready), 32'd0);
        chk("full_jk_a6", 32'({j, k}), 32'b10);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("full_jk_%0d", c), 32'({j, k}), 32'(t3_jk[c]));
        end
        chk("full_done", 32'(done_cnt), 32'd5);
        chk("full_rdy_end", 32'(cmd_ready), 32'd1);
        tick();
        chk("full_idle", 32'(busy), 32'd0);

        // Toggle before any Set/Reset leaves the model unknown
        do_reset();
        q_mode = 2;
        push1(2'b11, 4'd4);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("tog_expv_%0d", c), 32'(exp_valid), 32'd0);
            chk($sformatf("tog_mism_%0d", c), 32'(mismatch), 32'd0);
        end
        chk("tog_expq", 32'(exp_q), 32'd0);
        chk("tog_done", 32'(done_cnt), 32'd1);
        q_mode = 0;
        push1(2'b01, 4'd1);
        tick();
        chk("rstop_expv_e1", 32'(exp_valid), 32'd0);
        tick();
        chk("rstop_expv_e2", 32'(exp_valid), 32'd1);
        chk("rstop_expq", 32'(exp_q), 32'd0);
        tick();
        chk("rstop_mism", 32'(mismatch), 32'd0);

        // Stuck feedback sets the sticky mismatch
        do_reset();
        q_mode = 1;
        push1(2'b10, 4'd2);
        tick();
        tick();
        chk("stk_mism_pre", 32'(mismatch), 32'd0);
        chk("stk_expv", 32'(exp_valid), 32'd1);
        tick();
        chk("stk_mism_set", 32'(mismatch), 32'd1);
        q_mode = 0;
        tick();
        tick();
        tick();
        chk("stk_mism_hold", 32'(mismatch), 32'd1);
        do_reset();
        chk("stk_mism_clr", 32'(mismatch), 32'd0);

        // Reset mid-RUN with a queued command and a same-edge push
        do_reset();
        push1(2'b10, 4'd1);
        push1(2'b11, 4'd8);
        push1(2'b10, 4'd2);
        tick();
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_jk", 32'({j, k}), 32'b11);
        chk("mid_expv", 32'(exp_valid), 32'd1);
        chk("mid_done", 32'(done_cnt), 32'd1);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_len   = 4'd3;
        tick();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        chk("mid_rst_jk", 32'({j, k}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done_cnt), 32'd0);
        chk("mid_rst_expv", 32'(exp_valid), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        tick();
        tick();
        chk("mid_empty_busy", 32'(busy), 32'd0);
        chk("mid_empty_jk", 32'({j, k}), 32'd0);
        push1(2'b10, 4'd0);
        tick();
        chk("len0_jk_e1", 32'({j, k}), 32'b10);
        chk("len0_busy", 32'(busy), 32'd1);
        tick();
        chk("len0_jk_e2", 32'({j, k}), 32'd0);
        chk("len0_done", 32'(done_cnt), 32'd1);
        chk("len0_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
